// File: rtl/z80_bus_tracer.sv
// ----------------------------------------------------------------------------
// z80_bus_tracer
//
// Passive Z80 bus observer. Watches the CPU read/write strobes, classifies
// each completed bus cycle (memory read/write, I/O read/write, M1 fetch) and
// logs it into a show-ahead FIFO drained through a valid/ready port.
//
// Optional feature macro: TRACE_TIMESTAMP_EN
//   defined   - free-running TS_W-bit timestamp is stored with every event
//   undefined - no timestamp storage, out_ts is tied to zero
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   TS_W   timestamp width
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   en                             capture enable (sampled at end of cycle)
//   A, D                           CPU address / data bus (observed only)
//   nMREQ, nIORQ, nRD, nWR, nM1    CPU control strobes, active-low
//   out_valid, out_ready           FIFO head handshake
//   out_type, out_addr, out_data   head event fields
//   out_ts                         head event timestamp
//   overflow                       sticky, set when an event is dropped
//   drop_count                     dropped event count, saturating at 255
// ----------------------------------------------------------------------------
module z80_bus_tracer #(
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [15:0]     A,
    input  logic [7:0]      D,
    input  logic            nMREQ,
    input  logic            nIORQ,
    input  logic            nRD,
    input  logic            nWR,
    input  logic            nM1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_type,
    output logic [15:0]     out_addr,
    output logic [7:0]      out_data,
    output logic [TS_W-1:0] out_ts,
    output logic            overflow,
    output logic [7:0]      drop_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        EV_MEM_RD = 3'd0,
        EV_MEM_WR = 3'd1,
        EV_IO_RD  = 3'd2,
        EV_IO_WR  = 3'd3,
        EV_M1     = 3'd4
    } ev_type_t;

    // ------------------------------------------------------------------
    // Strobe tracking and cycle classification
    // ------------------------------------------------------------------
    logic     s;
    logic     s_q;
    logic     eoc;
    logic     cls_ok;
    ev_type_t cls_type;

    assign s   = ~nRD | ~nWR;
    assign eoc = s_q & ~s;

    always_comb begin
        cls_ok   = 1'b1;
        cls_type = EV_MEM_RD;
        if (~nMREQ & ~nRD & ~nM1)  cls_type = EV_M1;
        else if (~nMREQ & ~nRD)    cls_type = EV_MEM_RD;
        else if (~nMREQ & ~nWR)    cls_type = EV_MEM_WR;
        else if (~nIORQ & ~nRD)    cls_type = EV_IO_RD;
        else if (~nIORQ & ~nWR)    cls_type = EV_IO_WR;
        else                       cls_ok   = 1'b0;
    end

    // Shadow of the most recent strobe-active sample; the last one wins.
    logic        sh_ok;
    ev_type_t    sh_type;
    logic [15:0] sh_addr;
    logic [7:0]  sh_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q     <= 1'b0;
            sh_ok   <= 1'b0;
            sh_type <= EV_MEM_RD;
            sh_addr <= '0;
            sh_data <= '0;
        end else begin
            s_q <= s;
            if (s) begin
                sh_ok   <= cls_ok;
                sh_type <= cls_type;
                sh_addr <= A;
                sh_data <= D;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          empty;
    logic          full;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          drop;

    assign wr_idx   = wr_ptr[AW-1:0];
    assign rd_idx   = rd_ptr[AW-1:0];
    assign empty    = (wr_ptr == rd_ptr);
    // count == DEPTH: same index, wrap bits differ
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign pop      = ~empty & out_ready;
    assign push_req = eoc & en & sh_ok;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    logic [2:0]  mem_type [DEPTH];
    logic [15:0] mem_addr [DEPTH];
    logic [7:0]  mem_data [DEPTH];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_type[wr_idx] <= sh_type;
            mem_addr[wr_idx] <= sh_addr;
            mem_data[wr_idx] <= sh_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
        end
    end

    // Head fields are masked while empty so stale storage never shows
    // (storage itself is not reset).
    assign out_valid = ~empty;
    assign out_type  = out_valid ? mem_type[rd_idx] : '0;
    assign out_addr  = out_valid ? mem_addr[rd_idx] : '0;
    assign out_data  = out_valid ? mem_data[rd_idx] : '0;

    // ------------------------------------------------------------------
    // Optional timestamp
    // ------------------------------------------------------------------
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] mem_ts [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) ts <= '0;
        else       ts <= ts + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_ts[wr_idx] <= ts;
    end

    assign out_ts = out_valid ? mem_ts[rd_idx] : '0;
`else
    assign out_ts = '0;
`endif

endmodule
